// File: rtl/rv32i_types.sv
// rv32i_types: shared memory-interface types for the RV32I core.
// Provides the request-type encoding used by mem_responder.
package rv32i_types;
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_t;
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: word-organised storage with combinational read and two write ports.
// Ports: clk; waddr/wbe/wdata byte-enabled write (priority); init_we/init_addr/init_data
// full-word write; raddr/rdata combinational read.
module mem_word_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [3:0]            wbe,
    input  logic [31:0]           wdata,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [31:0]           init_data,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**DEPTH_LOG2];

    // The init write is dropped entirely when the byte port touches the same word.
    always_ff @(posedge clk) begin
        if (init_we && !(|wbe && init_addr == waddr)) mem[init_addr] <= init_data;
        for (int i = 0; i < 4; i++)
            if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder with byte-enabled word array.
// Ports: clk, rst (sync, active-high); mem_address/mem_read/mem_write/mem_byte_enable/
// mem_wdata request; mem_rdata/mem_resp response; proto_err violation pulse;
// init_we/init_addr/init_data full-word preload.
module mem_responder
    import rv32i_types::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_address,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [3:0]            mem_byte_enable,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_resp,
    output logic                  proto_err,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [31:0]           init_data
);
    if (LATENCY < 1) begin : g_bad_latency
        $error("mem_responder: LATENCY must be >= 1");
    end

    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_responder_state_t;

    mem_responder_state_t state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DEPTH_LOG2-1:0] idx_q, nxt_idx;
    mem_op_t               op_q, nxt_op;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q, arr_rdata;
    logic                  req, perr_n, unused_addr;

    assign req         = mem_read | mem_write;
    assign mem_resp    = (state == RESP);
    assign unused_addr = ^{mem_address[31:DEPTH_LOG2+2], mem_address[1:0]};

    // In IDLE the incoming request is used directly so LATENCY=1 can read on entry to RESP.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        perr_n  = 1'b0;
        nxt_idx = idx_q;
        nxt_op  = op_q;
        case (state)
            IDLE: begin
                nxt_idx = mem_address[DEPTH_LOG2+1:2];
                nxt_op  = mem_write ? OP_WRITE : OP_READ;
                if (req) begin
                    perr_n  = mem_read & mem_write;
                    state_n = (LATENCY == 1) ? RESP : WAIT;
                    cnt_n   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_n = IDLE;
                    perr_n  = 1'b1;
                end else if (cnt == '0) state_n = RESP;
                else cnt_n = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            proto_err <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            proto_err <= perr_n;
            if (state == IDLE && req) begin
                idx_q   <= nxt_idx;
                op_q    <= nxt_op;
                be_q    <= mem_byte_enable;
                wdata_q <= mem_wdata;
            end
            if (state_n == RESP && nxt_op == OP_READ) mem_rdata <= arr_rdata;
        end
    end

    mem_word_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk       (clk),
        .waddr     (idx_q),
        .wbe       ((state == RESP && op_q == OP_WRITE && !rst) ? be_q : 4'b0000),
        .wdata     (wdata_q),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .raddr     (nxt_idx),
        .rdata     (arr_rdata)
    );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench against a word-array reference model.
// Two instances (LATENCY 3 and 1) share address/data/init buses with separate requests.
module tb_mem_responder;
    logic        clk, rst;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [1:0]  rd, wr, resp, perr;
    logic [31:0] rdata [2];
    logic        init_we;
    logic [9:0]  init_addr;
    logic [31:0] init_data;

    int          lat [2] = '{3, 1};
    logic [31:0] model [2][1024];
    int          n_cmp = 0, n_bad = 0;

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .mem_address(addr), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_byte_enable(be), .mem_wdata(wdata), .mem_rdata(rdata[0]), .mem_resp(resp[0]),
        .proto_err(perr[0]), .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .mem_address(addr), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_byte_enable(be), .mem_wdata(wdata), .mem_rdata(rdata[1]), .mem_resp(resp[1]),
        .proto_err(perr[1]), .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        init_we   = 1'b1;
        init_addr = idx[9:0];
        init_data = d;
        step();
        init_we = 1'b0;
        model[0][idx] = d;
        model[1][idx] = d;
    endtask

    // One request on instance s; request raised in cycle T, response expected exactly in T+lat.
    task automatic txn(input int s, input bit w, input bit both, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input bit coll);
        int          idx;
        logic [31:0] exp, cd;
        bit          is_wr;
        idx   = int'(a[11:2]);
        exp   = model[s][idx];
        is_wr = w || both;
        cd    = $urandom;
        addr  = a;
        be    = b;
        wdata = d;
        rd[s] = !w || both;
        wr[s] = is_wr;
        for (int k = 1; k <= lat[s]; k++) begin
            step();
            chk($sformatf("resp%0d k%0d", s, k), 32'(resp[s]), 32'(k == lat[s]));
            if (k == 1) begin
                chk($sformatf("perr%0d", s), 32'(perr[s]), 32'(both));
                addr  = $urandom;
                wdata = $urandom;
                be    = 4'($urandom);
            end
            if (k == lat[s] && !is_wr) chk($sformatf("rdata%0d @%0d", s, idx), rdata[s], exp);
        end
        if (coll) begin
            init_we   = 1'b1;
            init_addr = idx[9:0];
            init_data = cd;
            model[1-s][idx] = cd;
        end
        if (is_wr)
            for (int i = 0; i < 4; i++)
                if (b[i]) model[s][idx][8*i +: 8] = d[8*i +: 8];
        if (coll && !(is_wr && b != 4'b0000)) model[s][idx] = cd;
        step();
        rd[s]   = 1'b0;
        wr[s]   = 1'b0;
        init_we = 1'b0;
        chk($sformatf("resp%0d idle", s), 32'(resp[s]), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] old30;
        rst = 1'b1; rd = '0; wr = '0; addr = '0; wdata = '0; be = '0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        step(); step();
        for (int s = 0; s < 2; s++) begin
            chk("rst resp", 32'(resp[s]), 32'd0);
            chk("rst rdata", rdata[s], 32'd0);
            chk("rst perr", 32'(perr[s]), 32'd0);
        end
        rst = 1'b0;
        step();
        chk("post rst resp", 32'(resp[0]), 32'd0);
        for (int i = 0; i < 1024; i++) preload(i, $urandom);

        preload(4, 32'hDEADBEEF);
        txn(0, 0, 0, 32'h10, 4'hF, 32'h0, 0);
        chk("deadbeef", rdata[0], 32'hDEADBEEF);

        preload(8, 32'hAAAAAAAA);
        txn(0, 1, 0, 32'h20, 4'b0101, 32'h11223344, 0);
        txn(0, 0, 0, 32'h20, 4'hF, 32'h0, 0);
        chk("be merge", rdata[0], 32'hAA22AA44);

        txn(0, 1, 0, 32'h24, 4'b0000, 32'h55555555, 0);
        txn(0, 0, 0, 32'h24, 4'hF, 32'h0, 0);

        for (int i = 0; i < 8; i++) txn(1, 0, 0, $urandom, 4'hF, 32'h0, 0);

        addr = 32'h40; rd[0] = 1'b1;
        step();
        rd[0] = 1'b0;
        chk("abort wait resp", 32'(resp[0]), 32'd0);
        step();
        chk("abort perr", 32'(perr[0]), 32'd1);
        chk("abort resp", 32'(resp[0]), 32'd0);
        step();
        chk("abort perr clr", 32'(perr[0]), 32'd0);
        chk("abort resp2", 32'(resp[0]), 32'd0);
        txn(0, 1, 1, 32'h44, 4'hF, 32'hCAFEF00D, 0);
        txn(0, 0, 0, 32'h44, 4'hF, 32'h0, 0);
        txn(1, 1, 1, 32'h48, 4'b1100, 32'h12345678, 0);
        txn(1, 0, 0, 32'h48, 4'hF, 32'h0, 0);

        old30 = model[0][12];
        addr = 32'h30; wdata = 32'h87654321; be = 4'hF; wr[0] = 1'b1;
        step(); step();
        rst = 1'b1;
        step();
        chk("rstwait resp", 32'(resp[0]), 32'd0);
        chk("rstwait rdata", rdata[0], 32'd0);
        chk("rstwait perr", 32'(perr[0]), 32'd0);
        rst = 1'b0; wr[0] = 1'b0;
        step();
        chk("rstwait idle", 32'(resp[0]), 32'd0);
        txn(0, 0, 0, 32'h30, 4'hF, 32'h0, 0);
        chk("rstwait keep", rdata[0], old30);

        preload(0, 32'h0BADF00D);
        txn(0, 0, 0, 32'h1000, 4'hF, 32'h0, 0);
        chk("alias", rdata[0], 32'h0BADF00D);
        txn(1, 0, 0, 32'hFFFF_F000, 4'hF, 32'h0, 0);
        chk("alias l1", rdata[1], 32'h0BADF00D);

        txn(1, 1, 0, 32'h80, 4'hF, 32'h77778888, 1);
        txn(1, 0, 0, 32'h80, 4'hF, 32'h0, 0);
        txn(0, 0, 0, 32'h80, 4'hF, 32'h0, 0);
        txn(0, 1, 0, 32'h84, 4'hF, 32'h9999AAAA, 1);
        txn(0, 0, 0, 32'h84, 4'hF, 32'h0, 0);

        for (int i = 0; i < 80; i++)
            txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                $urandom, 4'($urandom), $urandom, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
